jogador_automatico: RTL and testbench

- Hardware autoplayer that drives the memory-game circuit's player inputs (iniciar, chaves) and monitors its outputs (acertou, errou, pronto).
- It is the initiator end of the game interface. It plays the expected one-hot sequence, or injects one wrong play at a programmed round, then checks the game's final outcome.
- Used on the FPGA board and in simulation as a self-checking stimulus source in front of the game circuit.

---
 rtl/jogador_automatico.sv | 193 +++++++++++++++++++
 tb/tb_jogador_automatico.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jogador_automatico.sv
// Autoplayer for the memory game: drives iniciar/chaves with the expected
// one-hot play sequence (optionally with one wrong play at a chosen round),
// then watches acertou/errou/pronto and reports whether the game's outcome
// matched what the run expected.
module jogador_automatico #(
    parameter int NUM_JOGADAS  = 16,
    parameter int START_CYCLES = 5,
    parameter int HOLD_CYCLES  = 10,
    parameter int GAP_CYCLES   = 10,
    parameter int TIMEOUT      = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       comecar,
    input  logic       injetar_erro,
    input  logic [3:0] erro_em,
    input  logic       acertou,
    input  logic       errou,
    input  logic       pronto,
    output logic       iniciar,
    output logic [3:0] chaves,
    output logic       concluido,
    output logic       resultado_ok,
    output logic [1:0] codigo_falha,
    output logic [3:0] db_rodada,
    output logic [3:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        INICIA  = 3'd1,
        ESPERA  = 3'd2,
        JOGA    = 3'd3,
        SOLTA   = 3'd4,
        AGUARDA = 3'd5,
        FIM     = 3'd6
    } estado_t;

    // Timer reload values: the timer counts N-1 down to 0, so a state lasts N cycles
    localparam logic [7:0] T_START   = 8'(START_CYCLES - 1);
    localparam logic [7:0] T_HOLD    = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] T_GAP     = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] T_TIMEOUT = 8'(TIMEOUT - 1);
    localparam logic [3:0] ULTIMA    = 4'(NUM_JOGADAS - 1);

    estado_t    estado;
    logic [7:0] timer;
    logic [3:0] rodada;
    logic       inj_l;
    logic [3:0] erro_em_l;

    logic       inj_ativa;
    logic       eh_injetada;
    logic       rodada_final;
    logic       proxima_injetada;
    logic       saida_ok;

    // Correct play is one-hot by round mod 4; the wrong play is that value rotated left
    function automatic logic [3:0] jogada(input logic [3:0] r, input logic errada);
        logic [3:0] certa;
        certa = 4'b0001 << r[1:0];
        return errada ? {certa[2:0], certa[3]} : certa;
    endfunction

    // An out-of-range injection round means the run simply plays to the end
    assign inj_ativa        = inj_l && ({1'b0, erro_em_l} < 5'(NUM_JOGADAS));
    assign eh_injetada      = inj_ativa && (rodada == erro_em_l);
    assign rodada_final     = eh_injetada || (rodada == ULTIMA);
    assign proxima_injetada = inj_ativa && ((rodada + 4'd1) == erro_em_l);
    assign saida_ok         = inj_ativa ? errou : acertou;

    assign db_rodada = rodada;
    assign db_estado = {1'b0, estado};

    // Sequencer: all outputs are registered and change on the edge entering a state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            timer        <= 8'd0;
            rodada       <= 4'd0;
            inj_l        <= 1'b0;
            erro_em_l    <= 4'd0;
            iniciar      <= 1'b0;
            chaves       <= 4'd0;
            concluido    <= 1'b0;
            resultado_ok <= 1'b0;
            codigo_falha <= 2'b00;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (comecar) begin
                        inj_l        <= injetar_erro;
                        erro_em_l    <= erro_em;
                        concluido    <= 1'b0;
                        resultado_ok <= 1'b0;
                        codigo_falha <= 2'b00;
                        rodada       <= 4'd0;
                        iniciar      <= 1'b1;
                        chaves       <= 4'd0;
                        timer        <= T_START;
                        estado       <= INICIA;
                    end
                end
                INICIA: begin
                    if (timer == 8'd0) begin
                        iniciar <= 1'b0;
                        timer   <= T_GAP;
                        estado  <= ESPERA;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                ESPERA: begin
                    if (timer == 8'd0) begin
                        chaves <= jogada(rodada, eh_injetada);
                        timer  <= T_HOLD;
                        estado <= JOGA;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                JOGA: begin
                    // A game may finish while the last play is still held
                    if (rodada_final && pronto) begin
                        resultado_ok <= saida_ok;
                        codigo_falha <= saida_ok ? 2'b00 : 2'b11;
                        concluido    <= 1'b1;
                        chaves       <= 4'd0;
                        timer        <= 8'd0;
                        estado       <= FIM;
                    end else if (timer == 8'd0) begin
                        chaves <= 4'd0;
                        timer  <= T_GAP;
                        estado <= SOLTA;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                SOLTA: begin
                    if (rodada_final && pronto) begin
                        resultado_ok <= saida_ok;
                        codigo_falha <= saida_ok ? 2'b00 : 2'b11;
                        concluido    <= 1'b1;
                        timer        <= 8'd0;
                        estado       <= FIM;
                    end else if (errou && !eh_injetada) begin
                        codigo_falha <= 2'b01;
                        concluido    <= 1'b1;
                        timer        <= 8'd0;
                        estado       <= FIM;
                    end else if (timer == 8'd0) begin
                        if (rodada_final) begin
                            timer  <= T_TIMEOUT;
                            estado <= AGUARDA;
                        end else begin
                            rodada <= rodada + 4'd1;
                            chaves <= jogada(rodada + 4'd1, proxima_injetada);
                            timer  <= T_HOLD;
                            estado <= JOGA;
                        end
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                AGUARDA: begin
                    if (pronto) begin
                        resultado_ok <= saida_ok;
                        codigo_falha <= saida_ok ? 2'b00 : 2'b11;
                        concluido    <= 1'b1;
                        timer        <= 8'd0;
                        estado       <= FIM;
                    end else if (timer == 8'd0) begin
                        codigo_falha <= 2'b10;
                        concluido    <= 1'b1;
                        estado       <= FIM;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                FIM: begin
                    iniciar <= 1'b0;
                    chaves  <= 4'd0;
                    timer   <= 8'd0;
                    estado  <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a small game model answers the autoplayer,
// a monitor records the iniciar/chaves waveform, and each run is compared
// against expectations derived from the game rules.
module tb_jogador_automatico;

    localparam int NJ      = 4;
    localparam int T_START = 5;
    localparam int T_HOLD  = 10;
    localparam int T_GAP   = 10;
    localparam int T_OUT   = 200;

    localparam int GOOD   = 0;  // honest game, answers after a delay
    localparam int LIAR   = 1;  // always claims success at the end
    localparam int SILENT = 2;  // never answers
    localparam int ERR1   = 3;  // raises errou after round 1

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       comecar = 1'b0;
    logic       injetar_erro = 1'b0;
    logic [3:0] erro_em = 4'd0;
    logic       acertou = 1'b0;
    logic       errou = 1'b0;
    logic       pronto = 1'b0;
    logic       iniciar;
    logic [3:0] chaves;
    logic       concluido;
    logic       resultado_ok;
    logic [1:0] codigo_falha;
    logic [3:0] db_rodada;
    logic [3:0] db_estado;

    jogador_automatico #(
        .NUM_JOGADAS (NJ),
        .START_CYCLES(T_START),
        .HOLD_CYCLES (T_HOLD),
        .GAP_CYCLES  (T_GAP),
        .TIMEOUT     (T_OUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .comecar     (comecar),
        .injetar_erro(injetar_erro),
        .erro_em     (erro_em),
        .acertou     (acertou),
        .errou       (errou),
        .pronto      (pronto),
        .iniciar     (iniciar),
        .chaves      (chaves),
        .concluido   (concluido),
        .resultado_ok(resultado_ok),
        .codigo_falha(codigo_falha),
        .db_rodada   (db_rodada),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Game model and waveform monitor, both working on the falling edge
    int         g_mode = GOOD;
    int         g_dly = 3;
    int         cyc = 0;
    int         k = 0;
    int         fire_at = -1;
    logic       f_ac, f_er, f_pr;
    logic       prev_ini = 1'b0;
    logic [3:0] prev_ch = 4'd0;
    logic       prev_conc = 1'b0;
    int         ini_len = 0;
    int         zrun = 0;
    int         last_rel = 0;
    int         conc_delta = -1;
    logic [3:0] play_val[$];
    int         play_len[$];
    int         gaps[$];

    always @(negedge clock) begin
        bit wrong_now;
        bit fin;
        cyc++;
        if (!reset) begin
            acertou = 1'b0; errou = 1'b0; pronto = 1'b0;
            fire_at = -1; prev_ini = 1'b0; prev_ch = 4'd0; prev_conc = 1'b0;
        end else begin
            if (fire_at == cyc) begin
                acertou = f_ac; errou = f_er; pronto = f_pr;
            end
            if (iniciar && !prev_ini) begin
                k = 0; fire_at = -1;
                acertou = 1'b0; errou = 1'b0; pronto = 1'b0;
                ini_len = 0; zrun = 0; conc_delta = -1;
                play_val.delete(); play_len.delete(); gaps.delete();
            end
            if (iniciar) begin
                ini_len++;
            end else if (chaves != 4'd0) begin
                if (chaves != prev_ch) begin
                    gaps.push_back(zrun);
                    zrun = 0;
                    play_val.push_back(chaves);
                    play_len.push_back(0);
                end
                play_len[play_len.size()-1]++;
            end else begin
                zrun++;
                if (prev_ch != 4'd0) begin
                    last_rel  = cyc;
                    wrong_now = (prev_ch != 4'(1 << (k % 4)));
                    fin       = wrong_now || (k == NJ - 1);
                    case (g_mode)
                        GOOD:    if (fin) begin f_ac = !wrong_now; f_er = wrong_now; f_pr = 1'b1; fire_at = cyc + g_dly; end
                        LIAR:    if (fin) begin f_ac = 1'b1; f_er = 1'b0; f_pr = 1'b1; fire_at = cyc + g_dly; end
                        ERR1:    if (k == 1) begin f_ac = 1'b0; f_er = 1'b1; f_pr = 1'b0; fire_at = cyc + g_dly; end
                        default: ;
                    endcase
                    k++;
                end
            end
            if (concluido && !prev_conc) conc_delta = cyc - last_rel;
            prev_ini  = iniciar;
            prev_ch   = chaves;
            prev_conc = concluido;
        end
    end

    // Expected outcome from the game rules
    function automatic void modelo(input bit inj, input logic [3:0] em, input int mode,
                                   output bit ok, output logic [1:0] cod, output int rod);
        bit aplica;
        aplica = inj && (int'(em) < NJ);
        rod = aplica ? int'(em) : NJ - 1;
        case (mode)
            GOOD:    begin ok = 1'b1; cod = 2'b00; end
            LIAR:    begin ok = !aplica; cod = aplica ? 2'b11 : 2'b00; end
            SILENT:  begin ok = 1'b0; cod = 2'b10; end
            default: begin ok = 1'b0; cod = 2'b01; rod = 1; end
        endcase
    endfunction

    task automatic run_case(input bit inj, input logic [3:0] em, input int mode, input int dly,
                            input bit ex_ok, input logic [1:0] ex_cod, input int ex_rod, input string nm);
        bit seen;
        bit aplica;
        int nplays;
        int exp_delta;
        logic [3:0] exp_v;
        g_mode = mode;
        g_dly  = dly;
        @(negedge clock);
        injetar_erro = inj; erro_em = em; comecar = 1'b1;
        @(negedge clock);
        comecar = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            if (concluido) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            chk({nm, ".concluido_timeout"}, 0, 1);
            return;
        end
        @(negedge clock);
        aplica    = inj && (int'(em) < NJ);
        nplays    = ex_rod + 1;
        exp_delta = (mode == SILENT) ? (T_GAP + T_OUT) : (dly + 1);
        chk({nm, ".concluido"}, 32'(concluido), 1);
        chk({nm, ".resultado_ok"}, 32'(resultado_ok), 32'(ex_ok));
        chk({nm, ".codigo_falha"}, 32'(codigo_falha), 32'(ex_cod));
        chk({nm, ".db_rodada"}, 32'(db_rodada), 32'(ex_rod));
        chk({nm, ".db_estado"}, 32'(db_estado), 0);
        chk({nm, ".ini_len"}, 32'(ini_len), T_START);
        chk({nm, ".n_plays"}, 32'(play_val.size()), 32'(nplays));
        chk({nm, ".latency"}, 32'(conc_delta), 32'(exp_delta));
        for (int r = 0; r < nplays && r < play_val.size(); r++) begin
            exp_v = (aplica && r == int'(em)) ? 4'(1 << ((r + 1) % 4)) : 4'(1 << (r % 4));
            chk($sformatf("%s.play%0d", nm, r), 32'(play_val[r]), 32'(exp_v));
            chk($sformatf("%s.hold%0d", nm, r), 32'(play_len[r]), T_HOLD);
            chk($sformatf("%s.gap%0d", nm, r), 32'(gaps[r]), T_GAP);
        end
    endtask

    typedef struct {
        bit         inj;
        logic [3:0] em;
        int         mode;
        int         dly;
        bit         ok;
        logic [1:0] cod;
        int         rod;
    } vec_t;

    vec_t tab[8];

    initial begin
        bit         r_ok;
        logic [1:0] r_cod;
        int         r_rod;
        bit         r_inj;
        logic [3:0] r_em;
        int         r_mode;
        int         r_dly;
        bit         seen;

        tab[0] = '{1'b0, 4'd0, GOOD,   3,  1'b1, 2'b00, 3};
        tab[1] = '{1'b1, 4'd3, GOOD,   15, 1'b1, 2'b00, 3};
        tab[2] = '{1'b0, 4'd0, ERR1,   3,  1'b0, 2'b01, 1};
        tab[3] = '{1'b0, 4'd0, SILENT, 1,  1'b0, 2'b10, 3};
        tab[4] = '{1'b1, 4'd0, LIAR,   3,  1'b0, 2'b11, 0};
        tab[5] = '{1'b1, 4'd5, GOOD,   5,  1'b1, 2'b00, 3};
        tab[6] = '{1'b1, 4'd2, GOOD,   1,  1'b1, 2'b00, 2};
        tab[7] = '{1'b0, 4'd0, LIAR,   12, 1'b1, 2'b00, 3};

        // Reset state
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst.iniciar", 32'(iniciar), 0);
        chk("rst.chaves", 32'(chaves), 0);
        chk("rst.concluido", 32'(concluido), 0);
        chk("rst.resultado_ok", 32'(resultado_ok), 0);
        chk("rst.codigo_falha", 32'(codigo_falha), 0);
        chk("rst.db_rodada", 32'(db_rodada), 0);
        chk("rst.db_estado", 32'(db_estado), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_case(tab[i].inj, tab[i].em, tab[i].mode, tab[i].dly,
                     tab[i].ok, tab[i].cod, tab[i].rod, $sformatf("vec%0d", i));
        end

        // comecar while a run is in progress must be ignored
        fork
            run_case(1'b0, 4'd0, GOOD, 4, 1'b1, 2'b00, 3, "ignora");
            begin
                seen = 1'b0;
                for (int n = 0; n < 200; n++) begin
                    @(negedge clock);
                    if (chaves != 4'd0) begin seen = 1'b1; break; end
                end
                chk("ignora.play_seen", 32'(seen), 1);
                @(negedge clock);
                injetar_erro = 1'b1; erro_em = 4'd0; comecar = 1'b1;
                @(negedge clock);
                comecar = 1'b0; injetar_erro = 1'b0;
            end
        join

        // Asynchronous reset in the middle of a play
        g_mode = GOOD; g_dly = 3;
        @(negedge clock);
        injetar_erro = 1'b0; erro_em = 4'd0; comecar = 1'b1;
        @(negedge clock);
        comecar = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (chaves != 4'd0) begin seen = 1'b1; break; end
        end
        chk("mid_rst.play_seen", 32'(seen), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst.chaves", 32'(chaves), 0);
        chk("mid_rst.iniciar", 32'(iniciar), 0);
        chk("mid_rst.concluido", 32'(concluido), 0);
        chk("mid_rst.db_estado", 32'(db_estado), 0);
        chk("mid_rst.db_rodada", 32'(db_rodada), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        chk("post_rst.db_estado", 32'(db_estado), 0);
        chk("post_rst.chaves", 32'(chaves), 0);
        chk("post_rst.concluido", 32'(concluido), 0);
        chk("post_rst.resultado_ok", 32'(resultado_ok), 0);

        // Randomized runs against the rule-based model
        for (int i = 0; i < 12; i++) begin
            r_inj  = 1'($urandom_range(0, 1));
            r_em   = 4'($urandom_range(0, 7));
            r_mode = ($urandom_range(0, 3) == 0) ? LIAR : GOOD;
            r_dly  = $urandom_range(1, 25);
            modelo(r_inj, r_em, r_mode, r_ok, r_cod, r_rod);
            run_case(r_inj, r_em, r_mode, r_dly, r_ok, r_cod, r_rod, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
